// File: rtl/uart_tx_arbiter_if.sv
// Request / TX-side signal bundle for uart_tx_arbiter.
// The slave modport is the arbiter; the master modport is whoever drives requests and the UART TX status.
interface uart_tx_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  localparam int GW = $clog2(N_REQ);

  logic [N_REQ-1:0]        req_pulse;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic                    tx_busy;
  logic                    tx_done;
  logic                    tx_start;
  logic [DATA_W-1:0]       tx_data;
  logic [GW-1:0]           grant_id;
  logic [N_REQ-1:0]        pending;
  logic [N_REQ-1:0]        overrun;
  logic                    timeout_err;

  modport master (
    output req_pulse, req_data, tx_busy, tx_done,
    input  tx_start, tx_data, grant_id, pending, overrun, timeout_err
  );

  modport slave (
    input  req_pulse, req_data, tx_busy, tx_done,
    output tx_start, tx_data, grant_id, pending, overrun, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ one-byte requesters,
// with a per-requester pending slot and a watchdog on the TX completion pulse.
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                 clk,
  input  logic                 RSTn,
  uart_tx_arbiter_if.slave     bus
);
  localparam int GW   = $clog2(N_REQ);
  localparam int WD_W = $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] slot_q [N_REQ];
  logic [DATA_W-1:0] slot_d [N_REQ];
  logic [N_REQ-1:0]  pending_q, pending_d;
  logic [N_REQ-1:0]  overrun_q, overrun_d;
  logic [GW-1:0]     last_q, last_d;
  logic [GW-1:0]     grant_id_q, grant_id_d;
  logic [WD_W-1:0]   wd_q, wd_d, wd_inc;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              timeout_q, timeout_d;
  logic [GW-1:0]     rr_grant, cand;
  logic              rr_found, launch, wd_expired;

  // First pending requester after last_q; descending scan so the nearest one wins.
  always_comb begin
    rr_grant = '0;
    rr_found = 1'b0;
    cand     = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = GW'((int'(last_q) + k) % N_REQ);
      if (pending_q[cand]) begin
        rr_grant = cand;
        rr_found = 1'b1;
      end
    end
  end

  assign launch = (state_q == IDLE) && rr_found && !bus.tx_busy;
  assign wd_inc = wd_q + WD_W'(1);
  // Abort decided when the count reaches TIMEOUT_CYC-1, so timeout_err lands TIMEOUT_CYC cycles after tx_start.
  assign wd_expired = (wd_inc == WD_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (launch) state_d = START;
      START:     state_d = WAIT_DONE;
      WAIT_DONE: if (bus.tx_done || wd_expired) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // NOTE: every next-state value gets a default before any branch, so no latch is inferred.
  always_comb begin
    pending_d  = pending_q;
    slot_d     = slot_q;
    overrun_d  = '0;
    tx_start_d = 1'b0;
    timeout_d  = 1'b0;
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;
    last_d     = last_q;
    wd_d       = wd_q;

    unique case (state_q)
      IDLE: if (launch) begin
        tx_start_d = 1'b1;
        tx_data_d  = slot_q[rr_grant];
        grant_id_d = rr_grant;
      end
      START: begin
        pending_d[grant_id_q] = 1'b0;
        last_d                = grant_id_q;
        wd_d                  = '0;
      end
      WAIT_DONE: begin
        wd_d = wd_inc;
        if (!bus.tx_done && wd_expired) timeout_d = 1'b1;
      end
      default: ;
    endcase

    // A request arriving while its slot is being released refills it instead of overrunning.
    for (int i = 0; i < N_REQ; i++) begin
      if (bus.req_pulse[i]) begin
        if (!pending_q[i] || (state_q == START && grant_id_q == GW'(i))) begin
          pending_d[i] = 1'b1;
          slot_d[i]    = bus.req_data[i*DATA_W +: DATA_W];
        end else begin
          overrun_d[i] = 1'b1;
        end
      end
    end
  end

  // NOTE: the slot array is reset as well, so a grant can never expose a stale pre-reset byte.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < N_REQ; i++) slot_q[i] <= '0;
      pending_q  <= '0;
      overrun_q  <= '0;
      last_q     <= GW'(N_REQ - 1);
      grant_id_q <= '0;
      wd_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      last_q     <= last_d;
      grant_id_q <= grant_id_d;
      wd_q       <= wd_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.pending     = pending_q;
  assign bus.overrun     = overrun_q;
  assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a transaction-level model predicts start, overrun,
// timeout and pending events per cycle; a negedge monitor compares them with the DUT.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic clk  = 1'b0;
  logic RSTn = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus ();

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT_CYC(TO)) dut (
    .clk  (clk),
    .RSTn (RSTn),
    .bus  (bus)
  );

  typedef struct {int cyc; logic [W-1:0] data; int id;} start_t;
  typedef struct {int cyc; logic [N-1:0] mask;} ev_t;

  start_t st_q[$];
  ev_t    ov_q[$];
  ev_t    pend_q[$];
  int     to_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: pending set, byte store, round-robin pointer and the current transfer window.
  logic [N-1:0] mpend;
  logic [W-1:0] mbyte [N];
  int  mlast, m_idle_from, m_start, m_gnt, m_done_at;
  bit  m_inflight;
  int  tx_len    = 10;
  bit  hang_next = 1'b0;
  bit  spurious  = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_zero(string tag);
    check({tag, "_tx_start"},    32'(bus.tx_start),    0);
    check({tag, "_tx_data"},     32'(bus.tx_data),     0);
    check({tag, "_grant_id"},    32'(bus.grant_id),    0);
    check({tag, "_pending"},     32'(bus.pending),     0);
    check({tag, "_overrun"},     32'(bus.overrun),     0);
    check({tag, "_timeout_err"}, 32'(bus.timeout_err), 0);
  endtask

  function automatic logic [N*W-1:0] put(logic [N*W-1:0] v, int i, logic [W-1:0] b);
    v[i*W +: W] = b;
    return v;
  endfunction

  task automatic model_reset();
    mpend = '0;
    for (int i = 0; i < N; i++) mbyte[i] = '0;
    mlast       = N - 1;
    m_inflight  = 1'b0;
    m_start     = -1000;
    m_gnt       = 0;
    m_done_at   = -1000;
    m_idle_from = cyc;
    hang_next   = 1'b0;
    st_q.delete(); ov_q.delete(); pend_q.delete(); to_q.delete();
  endtask

  // Apply the rules for cycle n; every prediction is for cycle n+1.
  task automatic model_step(int n, logic [N-1:0] p, logic [N*W-1:0] d, bit busy, bit done);
    logic [N-1:0] np, ov;
    bit     clr;
    int     g;
    start_t s;
    ev_t    e;
    np = mpend; ov = '0; g = -1;
    if (m_inflight && n > m_start) begin
      if (done) begin
        m_inflight = 1'b0; m_idle_from = n + 1;
      end else if (n == m_start + TO - 1) begin
        m_inflight = 1'b0; m_idle_from = n + 1; to_q.push_back(n + 1);
      end
    end
    if (!m_inflight && n >= m_idle_from && mpend != '0 && !busy) begin
      for (int k = 1; k <= N; k++)
        if (g < 0 && mpend[(mlast + k) % N]) g = (mlast + k) % N;
      s.cyc = n + 1; s.data = mbyte[g]; s.id = g;
      st_q.push_back(s);
      m_inflight = 1'b1; m_start = n + 1; m_gnt = g;
      m_done_at  = hang_next ? m_start + 100000 : m_start + tx_len;
      hang_next  = 1'b0;
    end
    clr = (n == m_start);
    if (clr) begin np[m_gnt] = 1'b0; mlast = m_gnt; end
    for (int i = 0; i < N; i++) begin
      if (p[i]) begin
        if (!mpend[i] || (clr && m_gnt == i)) begin
          np[i] = 1'b1; mbyte[i] = d[i*W +: W];
        end else ov[i] = 1'b1;
      end
    end
    if (ov != '0) begin e.cyc = n + 1; e.mask = ov; ov_q.push_back(e); end
    e.cyc = n + 1; e.mask = np; pend_q.push_back(e);
    mpend = np;
  endtask

  // Drive one cycle: requests from the caller, TX status from the scripted transmitter.
  task automatic step(logic [N-1:0] p, logic [N*W-1:0] d);
    bit busy, done;
    busy = m_inflight && cyc > m_start && cyc < m_done_at;
    done = m_inflight && cyc == m_done_at;
    if (spurious && !(m_inflight && cyc > m_start)) begin
      if ($urandom_range(0, 9) == 0) done = 1'b1;
      if (!m_inflight && $urandom_range(0, 5) == 0) busy = 1'b1;
    end
    bus.req_pulse = p; bus.req_data = d; bus.tx_busy = busy; bus.tx_done = done;
    model_step(cyc, p, d, busy, done);
    @(posedge clk); #1;
  endtask

  task automatic wait_start(int id);
    int left = 300;
    while (!(m_inflight && m_gnt == id && cyc == m_start) && left > 0) begin
      step('0, '0); left--;
    end
    check($sformatf("wait_start_%0d", id), 32'(m_inflight && m_gnt == id && cyc == m_start), 1);
  endtask

  task automatic drain(string tag);
    int left = 2000;
    while ((m_inflight || mpend != '0) && left > 0) begin
      step('0, '0); left--;
    end
    check({"drain_", tag}, 32'(m_inflight || mpend != '0), 0);
    repeat (3) step('0, '0);
  endtask

  // Monitor: each cycle, compare every event class the model predicted (or did not) for this cycle.
  always @(negedge clk) begin
    bit e;
    if (RSTn) begin
      e = st_q.size() > 0 && st_q[0].cyc == cyc;
      check("tx_start", 32'(bus.tx_start), 32'(e));
      if (e) begin
        if (bus.tx_start) begin
          check("tx_data", 32'(bus.tx_data), 32'(st_q[0].data));
          check("grant_id", 32'(bus.grant_id), st_q[0].id);
        end
        void'(st_q.pop_front());
      end
      e = to_q.size() > 0 && to_q[0] == cyc;
      check("timeout_err", 32'(bus.timeout_err), 32'(e));
      if (e) void'(to_q.pop_front());
      e = ov_q.size() > 0 && ov_q[0].cyc == cyc;
      check("overrun", 32'(bus.overrun), e ? 32'(ov_q[0].mask) : 0);
      if (e) void'(ov_q.pop_front());
      if (pend_q.size() > 0 && pend_q[0].cyc == cyc) begin
        check("pending", 32'(bus.pending), 32'(pend_q[0].mask));
        void'(pend_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    logic [N*W-1:0] d;
    int s;
    bus.req_pulse = '0; bus.req_data = '0; bus.tx_busy = 1'b0; bus.tx_done = 1'b0;
    #1 RSTn = 1'b0;
    #2 check_zero("rst");
    repeat (2) @(posedge clk);
    #1 RSTn = 1'b1;
    model_reset();

    // Round-robin from reset, then re-pulse 0 and 3 during grant 1.
    tx_len = 10;
    d = '0;
    for (int i = 0; i < N; i++) d = put(d, i, W'(8'h10 + i));
    step(4'b1111, d);
    wait_start(1);
    step('0, '0);
    step(4'b1001, put(put('0, 0, 8'h20), 3, 8'h23));
    drain("rr");

    // Single request with its exact latency.
    step(4'b0100, put('0, 2, 8'hA5));
    check("single_pending_t1", 32'(bus.pending), 32'h4);
    step('0, '0);
    check("single_start_t2", 32'(bus.tx_start), 1);
    check("single_data_t2", 32'(bus.tx_data), 32'hA5);
    check("single_gid_t2", 32'(bus.grant_id), 2);
    drain("single");
    check("single_pending_end", 32'(bus.pending), 0);

    // Overrun: second byte for requester 1 while requester 0 is on the wire.
    step(4'b0011, put(put('0, 0, 8'h30), 1, 8'h55));
    wait_start(0);
    repeat (3) step('0, '0);
    step(4'b0010, put('0, 1, 8'h66));
    check("overrun_pulse", 32'(bus.overrun), 32'h2);
    drain("overrun");

    // Accept-on-clear: new byte arrives in requester 1's START cycle.
    step(4'b0010, put('0, 1, 8'h21));
    wait_start(1);
    step(4'b0010, put('0, 1, 8'h77));
    check("aoc_pending1", 32'(bus.pending[1]), 1);
    check("aoc_no_overrun", 32'(bus.overrun), 0);
    drain("aoc");

    // Watchdog: first transfer never completes.
    hang_next = 1'b1;
    step(4'b1100, put(put('0, 2, 8'h40), 3, 8'h41));
    wait_start(2);
    s = cyc;
    repeat (TO - 1) step('0, '0);
    check("timeout_not_early", 32'(bus.timeout_err), 0);
    step('0, '0);
    check("timeout_cycle_offset", cyc - s, TO);
    check("timeout_at_limit", 32'(bus.timeout_err), 1);
    drain("timeout");

    // Asynchronous reset in WAIT_DONE with three requests still pending.
    hang_next = 1'b1;
    d = '0;
    for (int i = 0; i < N; i++) d = put(d, i, W'(8'h50 + i));
    step(4'b1111, d);
    repeat (5) step('0, '0);
    check("pre_reset_pending_cnt", 32'($countones(bus.pending)), 3);
    bus.req_pulse = '0; bus.tx_busy = 1'b0; bus.tx_done = 1'b0;
    #3 RSTn = 1'b0;
    #1 check_zero("rst_mid");
    repeat (2) @(posedge clk);
    #1 check_zero("rst_hold");
    RSTn = 1'b1;
    model_reset();
    repeat (20) step('0, '0);
    step(4'b0101, put(put('0, 0, 8'h60), 2, 8'h62));
    step('0, '0);
    check("post_rst_start", 32'(bus.tx_start), 1);
    check("post_rst_gid", 32'(bus.grant_id), 0);
    drain("post_reset");

    // Randomized traffic with variable frame lengths, hangs and stray TX strobes.
    spurious = 1'b1;
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] p;
      for (int i = 0; i < N; i++) p[i] = ($urandom_range(0, 7) == 0);
      d = '0;
      for (int i = 0; i < N; i++) d = put(d, i, W'($urandom));
      tx_len = $urandom_range(1, TO + 2);
      if ($urandom_range(0, 19) == 0) hang_next = 1'b1;
      step(p, d);
    end
    spurious  = 1'b0;
    hang_next = 1'b0;
    drain("random");

    repeat (5) step('0, '0);
    check("start_q_left", st_q.size(), 0);
    check("overrun_q_left", ov_q.size(), 0);
    check("timeout_q_left", to_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
